// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-master AXI-Lite arbiter.
// Holds the FSM state encoding, default bus widths and response codes.
package axi_lite_arb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int RESP_WIDTH_DEF = 3;

    localparam logic [RESP_WIDTH_DEF-1:0] RESP_OKAY  = 3'd0;
    localparam logic [RESP_WIDTH_DEF-1:0] RESP_ERROR = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority pointer
// moves to the other requester whenever the served index is committed.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] gnt
);

    logic prio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= 1'b0;
        else if (update)
            prio <= ~served;
    end

    always_comb begin
        gnt = '0;
        if (req[0] && (!req[1] || !prio))
            gnt[0] = 1'b1;
        else if (req[1])
            gnt[1] = 1'b1;
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Arbitrates two AXI-Lite masters onto one downstream slave port, carrying one
// transaction at a time; after the one-cycle grant all handshakes pass through.
module axi_lite_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RESP_WIDTH = RESP_WIDTH_DEF
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [RESP_WIDTH-1:0]   s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
    output logic                    m0_axi_awvalid,
    input  logic                    m0_axi_awready,
    output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
    output logic [DATA_WIDTH/8:0]   m0_axi_wstrb,
    output logic                    m0_axi_wvalid,
    input  logic                    m0_axi_wready,
    input  logic [RESP_WIDTH-1:0]   m0_axi_bresp,
    input  logic                    m0_axi_bvalid,
    output logic                    m0_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
    output logic                    m0_axi_arvalid,
    input  logic                    m0_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
    input  logic [RESP_WIDTH-1:0]   m0_axi_rresp,
    input  logic                    m0_axi_rvalid,
    output logic                    m0_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8 + 1;

    logic [1:0][ADDR_WIDTH-1:0] awaddr_in, araddr_in;
    logic [1:0][DATA_WIDTH-1:0] wdata_in;
    logic [1:0][STRB_WIDTH-1:0] wstrb_in;
    logic [1:0] awvalid_in, wvalid_in, bready_in, arvalid_in, rready_in;

    logic [1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0][RESP_WIDTH-1:0] s_bresp, s_rresp;
    logic [1:0][DATA_WIDTH-1:0] s_rdata;

    state_t     state;
    logic       gnt_idx;
    logic       aw_done, w_done;
    logic [1:0] wr_pref;

    logic [1:0] wr_req, rd_req, arb_gnt;
    logic       pick, pick_wr;
    logic       aw_fire, w_fire, b_fire, ar_fire, r_fire, ret_idle;

    assign awaddr_in  = {s1_axi_awaddr,  s0_axi_awaddr};
    assign araddr_in  = {s1_axi_araddr,  s0_axi_araddr};
    assign wdata_in   = {s1_axi_wdata,   s0_axi_wdata};
    assign wstrb_in   = {s1_axi_wstrb,   s0_axi_wstrb};
    assign awvalid_in = {s1_axi_awvalid, s0_axi_awvalid};
    assign wvalid_in  = {s1_axi_wvalid,  s0_axi_wvalid};
    assign bready_in  = {s1_axi_bready,  s0_axi_bready};
    assign arvalid_in = {s1_axi_arvalid, s0_axi_arvalid};
    assign rready_in  = {s1_axi_rready,  s0_axi_rready};

    assign wr_req  = awvalid_in & wvalid_in;
    assign rd_req  = arvalid_in;
    assign pick    = arb_gnt[1];
    // Write/read preference applies only when the winner has both pending.
    assign pick_wr = wr_req[pick] && (!rd_req[pick] || wr_pref[pick]);

    assign aw_fire  = m0_axi_awvalid & m0_axi_awready;
    assign w_fire   = m0_axi_wvalid  & m0_axi_wready;
    assign b_fire   = m0_axi_bvalid  & m0_axi_bready;
    assign ar_fire  = m0_axi_arvalid & m0_axi_arready;
    assign r_fire   = m0_axi_rvalid  & m0_axi_rready;
    assign ret_idle = b_fire | r_fire;

    rr_arbiter2 u_rr (
        .clk    (axi_aclk),
        .rst_n  (axi_aresetn),
        .req    (wr_req | rd_req),
        .update (ret_idle),
        .served (gnt_idx),
        .gnt    (arb_gnt)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state   <= IDLE;
            gnt_idx <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wr_pref <= '1;
        end else begin
            unique case (state)
                IDLE: if (|arb_gnt) begin
                    gnt_idx <= pick;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    state   <= pick_wr ? WR_ADDR : RD_ADDR;
                end
                WR_ADDR: begin
                    if ((aw_done || aw_fire) && (w_done || w_fire))
                        state <= WR_RESP;
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                WR_RESP: if (b_fire) begin
                    state            <= IDLE;
                    wr_pref[gnt_idx] <= 1'b0;
                end
                RD_ADDR: if (ar_fire) state <= RD_DATA;
                RD_DATA: if (r_fire) begin
                    state            <= IDLE;
                    wr_pref[gnt_idx] <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m0_axi_awaddr  = '0;
        m0_axi_awvalid = 1'b0;
        m0_axi_wdata   = '0;
        m0_axi_wstrb   = '0;
        m0_axi_wvalid  = 1'b0;
        m0_axi_bready  = 1'b0;
        m0_axi_araddr  = '0;
        m0_axi_arvalid = 1'b0;
        m0_axi_rready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        s_arready = '0;
        s_rvalid  = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        unique case (state)
            WR_ADDR: begin
                m0_axi_awaddr  = awaddr_in[gnt_idx];
                m0_axi_wdata   = wdata_in[gnt_idx];
                m0_axi_wstrb   = wstrb_in[gnt_idx];
                m0_axi_awvalid = awvalid_in[gnt_idx] & ~aw_done;
                m0_axi_wvalid  = wvalid_in[gnt_idx]  & ~w_done;
                s_awready[gnt_idx] = m0_axi_awready & ~aw_done;
                s_wready[gnt_idx]  = m0_axi_wready  & ~w_done;
            end
            WR_RESP: begin
                m0_axi_bready     = bready_in[gnt_idx];
                s_bvalid[gnt_idx] = m0_axi_bvalid;
                s_bresp[gnt_idx]  = m0_axi_bresp;
            end
            RD_ADDR: begin
                m0_axi_araddr      = araddr_in[gnt_idx];
                m0_axi_arvalid     = arvalid_in[gnt_idx];
                s_arready[gnt_idx] = m0_axi_arready;
            end
            RD_DATA: begin
                m0_axi_rready     = rready_in[gnt_idx];
                s_rvalid[gnt_idx] = m0_axi_rvalid;
                s_rdata[gnt_idx]  = m0_axi_rdata;
                s_rresp[gnt_idx]  = m0_axi_rresp;
            end
            default: ;
        endcase
    end

    assign s0_axi_awready = s_awready[0];
    assign s0_axi_wready  = s_wready[0];
    assign s0_axi_bvalid  = s_bvalid[0];
    assign s0_axi_bresp   = s_bresp[0];
    assign s0_axi_arready = s_arready[0];
    assign s0_axi_rvalid  = s_rvalid[0];
    assign s0_axi_rdata   = s_rdata[0];
    assign s0_axi_rresp   = s_rresp[0];
    assign s1_axi_awready = s_awready[1];
    assign s1_axi_wready  = s_wready[1];
    assign s1_axi_bvalid  = s_bvalid[1];
    assign s1_axi_bresp   = s_bresp[1];
    assign s1_axi_arready = s_arready[1];
    assign s1_axi_rvalid  = s_rvalid[1];
    assign s1_axi_rdata   = s_rdata[1];
    assign s1_axi_rresp   = s_rresp[1];

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level arbitration model.
module tb_axi_lite_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 3;
    localparam int SW = DW / 8 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][AW-1:0] awaddr, araddr;
    logic [1:0][DW-1:0] wdata, rdata;
    logic [1:0][SW-1:0] wstrb;
    logic [1:0][RW-1:0] bresp, rresp;
    logic [1:0] awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0] arvalid, arready, rvalid, rready;

    logic [AW-1:0] m0_awaddr, m0_araddr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [SW-1:0] m0_wstrb;
    logic [RW-1:0] m0_bresp, m0_rresp;
    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;

    int tests = 0;
    int fails = 0;

    // Transaction-level model: pending requests, rotating priority, per-master preference
    bit [1:0] pw, pr;
    int       rr_prio;
    bit [1:0] wr_pref;

    axi_lite_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s0_axi_awaddr(awaddr[0]), .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]),
        .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(wstrb[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
        .s0_axi_bresp(bresp[0]), .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]),
        .s0_axi_araddr(araddr[0]), .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]),
        .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]),
        .s1_axi_awaddr(awaddr[1]), .s1_axi_awvalid(awvalid[1]), .s1_axi_awready(awready[1]),
        .s1_axi_wdata(wdata[1]), .s1_axi_wstrb(wstrb[1]), .s1_axi_wvalid(wvalid[1]), .s1_axi_wready(wready[1]),
        .s1_axi_bresp(bresp[1]), .s1_axi_bvalid(bvalid[1]), .s1_axi_bready(bready[1]),
        .s1_axi_araddr(araddr[1]), .s1_axi_arvalid(arvalid[1]), .s1_axi_arready(arready[1]),
        .s1_axi_rdata(rdata[1]), .s1_axi_rresp(rresp[1]), .s1_axi_rvalid(rvalid[1]), .s1_axi_rready(rready[1]),
        .m0_axi_awaddr(m0_awaddr), .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready),
        .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb), .m0_axi_wvalid(m0_wvalid), .m0_axi_wready(m0_wready),
        .m0_axi_bresp(m0_bresp), .m0_axi_bvalid(m0_bvalid), .m0_axi_bready(m0_bready),
        .m0_axi_araddr(m0_araddr), .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready),
        .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp), .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input int n);
        chk($sformatf("quiet_s%0d", n),
            {awready[n], wready[n], bvalid[n], arready[n], rvalid[n], bresp[n], rresp[n], rdata[n]}, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0"}, {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready,
                           m0_awaddr, m0_wdata, m0_wstrb, m0_araddr}, '0);
        chk({tag, "_s"}, {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata}, '0);
    endtask

    task automatic req_write(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
        awaddr[n] = a; wdata[n] = d; wstrb[n] = s;
        awvalid[n] = 1'b1; wvalid[n] = 1'b1; pw[n] = 1'b1;
    endtask

    task automatic req_read(input int n, input logic [AW-1:0] a);
        araddr[n] = a; arvalid[n] = 1'b1; pr[n] = 1'b1;
    endtask

    function automatic void predict(output int m, output bit wr);
        bit r0, r1;
        r0 = pw[0] | pr[0];
        r1 = pw[1] | pr[1];
        if (r0 && r1) m = rr_prio;
        else m = r1 ? 1 : 0;
        if (pw[m] && pr[m]) wr = wr_pref[m];
        else wr = pw[m];
    endfunction

    // Entered with the DUT idle and requests already driven; leaves it idle again.
    task automatic serve(input int m, input bit wr, input int d1, input int d2, input int d3,
                         input logic [RW-1:0] resp, input logic [DW-1:0] rdat);
        int last;
        #1;
        chk("idle_m0_valid", {m0_awvalid, m0_wvalid, m0_arvalid}, '0);
        chk("idle_s_ready", {awready, wready, arready, bvalid, rvalid}, '0);
        tick();
        if (wr) begin
            last = (d1 > d2) ? d1 : d2;
            for (int c = 0; c <= last; c++) begin
                m0_awready = (c == d1);
                m0_wready  = (c == d2);
                #1;
                chk("m0_awvalid", m0_awvalid, c <= d1);
                chk("m0_wvalid", m0_wvalid, c <= d2);
                if (c <= d1) chk("m0_awaddr", m0_awaddr, awaddr[m]);
                if (c <= d2) chk("m0_wdata_strb", {m0_wdata, m0_wstrb}, {wdata[m], wstrb[m]});
                chk("s_awready", awready[m], c == d1);
                chk("s_wready", wready[m], c == d2);
                chk_quiet(1 - m);
                tick();
                if (c == d1) awvalid[m] = 1'b0;
                if (c == d2) wvalid[m] = 1'b0;
            end
            m0_awready = 1'b0;
            m0_wready = 1'b0;
            bready[m] = 1'b1;
            for (int c = 0; c <= d3; c++) begin
                m0_bvalid = (c == d3);
                m0_bresp  = (c == d3) ? resp : '0;
                #1;
                chk("m0_bready", m0_bready, 1'b1);
                chk("s_bvalid_bresp", {bvalid[m], bresp[m]}, {c == d3, (c == d3) ? resp : 3'd0});
                chk("m0_aw_quiet", {m0_awvalid, m0_wvalid}, '0);
                chk_quiet(1 - m);
                tick();
            end
            m0_bvalid = 1'b0;
            m0_bresp = '0;
            bready[m] = 1'b0;
            pw[m] = 1'b0;
        end else begin
            for (int c = 0; c <= d1; c++) begin
                m0_arready = (c == d1);
                #1;
                chk("m0_arvalid_addr", {m0_arvalid, m0_araddr}, {1'b1, araddr[m]});
                chk("s_arready", arready[m], c == d1);
                chk_quiet(1 - m);
                tick();
            end
            arvalid[m] = 1'b0;
            m0_arready = 1'b0;
            rready[m] = 1'b1;
            for (int c = 0; c <= d3; c++) begin
                m0_rvalid = (c == d3);
                m0_rdata  = (c == d3) ? rdat : '0;
                m0_rresp  = (c == d3) ? resp : '0;
                #1;
                chk("m0_rready", m0_rready, 1'b1);
                chk("s_rvalid_data", {rvalid[m], rdata[m], rresp[m]},
                    {c == d3, (c == d3) ? rdat : 32'd0, (c == d3) ? resp : 3'd0});
                chk("m0_ar_quiet", m0_arvalid, 1'b0);
                chk_quiet(1 - m);
                tick();
            end
            m0_rvalid = 1'b0;
            m0_rdata = '0;
            m0_rresp = '0;
            rready[m] = 1'b0;
            pr[m] = 1'b0;
        end
        rr_prio = 1 - m;
        wr_pref[m] = !wr;
    endtask

    task automatic run_one(input int d1, input int d2, input int d3,
                           input logic [RW-1:0] resp, input logic [DW-1:0] rdat);
        int m;
        bit wr;
        predict(m, wr);
        serve(m, wr, d1, d2, d3, resp, rdat);
    endtask

    initial begin
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
        m0_awready = 0; m0_wready = 0; m0_bvalid = 0; m0_bresp = '0;
        m0_arready = 0; m0_rvalid = 0; m0_rdata = '0; m0_rresp = '0;
        pw = '0; pr = '0; rr_prio = 0; wr_pref = 2'b11;

        #1;
        chk_all_zero("reset");
        #20;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Simultaneous writes after reset: s0 first, then s1
        req_write(0, 8'h00, 32'd34, 5'd15);
        req_write(1, 8'h10, 32'd37, 5'd15);
        run_one(0, 0, 0, 3'd1, '0);
        run_one(0, 0, 1, 3'd0, '0);

        req_read(1, 8'h08);
        run_one(0, 0, 1, 3'd2, 32'd23);

        // awready a cycle ahead of wready
        req_write(0, 8'h24, 32'hdead_beef, 5'h1f);
        run_one(0, 1, 0, 3'd0, '0);

        // s1 read cut short by reset while waiting for rvalid
        req_read(1, 8'h08);
        #1;
        tick();
        m0_arready = 1'b1;
        #1;
        chk("rst_ar_pass", {m0_arvalid, arready[1]}, 2'b11);
        tick();
        arvalid[1] = 1'b0;
        m0_arready = 1'b0;
        rready[1] = 1'b1;
        #1;
        chk("rst_rd_data", m0_rready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        rready[1] = 1'b0;
        pr = '0;
        rr_prio = 0;
        wr_pref = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_all_zero("after_mid_reset");

        // s0 write+read together, s1 write: s0 write, s1 write, then s0 read
        req_write(0, 8'h40, 32'h1234_5678, 5'h03);
        req_read(0, 8'h44);
        req_write(1, 8'h50, 32'h0bad_f00d, 5'h10);
        run_one(1, 0, 0, 3'd0, '0);
        run_one(0, 2, 2, 3'd2, '0);
        run_one(2, 0, 0, 3'd0, 32'h0000_aa55);

        for (int round = 0; round < 40; round++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(1, 0) == 1)
                    req_write(n, AW'($urandom), $urandom, SW'($urandom));
                if ($urandom_range(1, 0) == 1)
                    req_read(n, AW'($urandom));
            end
            while ((pw | pr) != 2'b00)
                run_one($urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0),
                        RW'($urandom), $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 3, bresp/rresp width.
REQ-004 SHALL have port axi_aclk  in  1  single clock for all ports.
REQ-005 SHALL have port axi_aresetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have, per requester n in {0,1}, ports sn_axi_awaddr in ADDR_WIDTH, sn_axi_awvalid in 1, sn_axi_awready out 1  write address.
REQ-007 SHALL have sn_axi_wdata in DATA_WIDTH, sn_axi_wstrb in DATA_WIDTH/8+1, sn_axi_wvalid in 1, sn_axi_wready out 1  write data.
REQ-008 SHALL have sn_axi_bresp out RESP_WIDTH, sn_axi_bvalid out 1, sn_axi_bready in 1  write response.
REQ-009 SHALL have sn_axi_araddr in ADDR_WIDTH, sn_axi_arvalid in 1, sn_axi_arready out 1  read address.
REQ-010 SHALL have sn_axi_rdata out DATA_WIDTH, sn_axi_rresp out RESP_WIDTH, sn_axi_rvalid out 1, sn_axi_rready in 1  read data.
REQ-011 SHALL have one downstream port m0_axi_* with the same five channels, directions mirrored and widths identical, driving the bus s0 port.

Function
REQ-012 SHALL carry at most one transaction (read or write) at a time.
REQ-013 SHALL use states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
REQ-014 IDLE: write request for n = sn_awvalid & sn_wvalid; read request = sn_arvalid; if any request, register grant and move to WR_ADDR or RD_ADDR on the next edge; no upstream ready is asserted in IDLE.
REQ-015 SHALL arbitrate masters round-robin: the master not granted last wins when both request; after reset master 0 has priority.
REQ-016 SHALL, within the granted master, alternate write/read priority when both are pending, starting with write after reset.
REQ-017 WR_ADDR: m0 awvalid/wvalid driven from granted master, payload muxed combinationally; granted sn_awready = m0_awready, sn_wready = m0_wready; aw_done and w_done flags track each handshake independently; go to WR_RESP once both are done (same-cycle completion allowed).
REQ-018 WR_ADDR SHALL deassert m0 awvalid/wvalid individually once its handshake has completed.
REQ-019 WR_RESP: m0_bready = granted sn_bready, granted sn_bvalid/bresp = m0 values; on bvalid & bready return to IDLE.
REQ-020 RD_ADDR: m0_arvalid/araddr from granted master, granted sn_arready = m0_arready; on handshake go to RD_DATA.
REQ-021 RD_DATA: m0_rready = granted sn_rready, granted sn_rvalid/rdata/rresp = m0 values; on handshake return to IDLE.
REQ-022 SHALL hold all ready/valid outputs of the non-granted master at 0, and its rdata/bresp at 0.
REQ-023 SHALL add exactly one cycle of latency (IDLE to grant); all subsequent handshakes are combinational pass-through.
REQ-024 SHALL update the round-robin pointer and write/read toggle only on return to IDLE.

Reset
REQ-025 Asserting axi_aresetn SHALL asynchronously force IDLE, clear grant, aw_done, w_done, set master-0 and write priority, including mid-transaction.
REQ-026 During reset all valid/ready outputs SHALL be 0 and all data/resp outputs 0.

Structure
REQ-027 Package axi_lite_arb_pkg SHALL hold the state enumeration, default width constants, and OKAY/ERROR response codes.
REQ-028 A sub-module rr_arbiter2 (2-way round-robin, request in, one-hot grant out, pointer update strobe) SHALL implement REQ-015.

Verification
REQ-029 s0 write awaddr=0x00, wdata=34, wstrb=15, m0 ready=1, bresp=1 -> m0_awvalid one cycle after request, s0_bvalid with bresp=1, return to IDLE.
REQ-030 s0 and s1 write simultaneously after reset -> s0 served first, then s1 (addr 0x10, data 37), s1 ports idle meanwhile.
REQ-031 s1 read araddr=0x08, m0_rdata=23 -> s1_rdata=23, rresp forwarded, s0_rvalid stays 0.
REQ-032 m0_awready one cycle before m0_wready -> m0_awvalid drops after first handshake, WR_RESP entered after second.
REQ-033 s0 requests write and read together, twice -> first grant write, second grant read.
REQ-034 Reset asserted in RD_DATA before rvalid -> all outputs 0 immediately, IDLE after release, master-0 priority.
